gui_heart_bar: RTL and testbench

- Parametrised HUD health bar for the VGA pixel pipeline.
- Draws MAX_HEARTS heart sprites in a row and reports pixel colour plus an opaque flag for the top-level colour mux.
- Animates health changes across frame ticks: lost hearts blink after damage, and healed hearts refill one at a time.
- Updates only at frame boundaries, so no tearing within a frame.

---
 rtl/gui_heart_bar_pkg.sv | 8 +
 rtl/heart_sprite_rom.sv | 45 ++++
 rtl/gui_heart_bar.sv | 158 +++++++++++++++
 tb/tb_gui_heart_bar.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gui_heart_bar_pkg.sv
// Shared constants and FSM state type for the HUD heart bar.
// TRANSPARENT marks sprite pixels that let the background through.
package gui_pkg;
   localparam logic [11:0] TRANSPARENT = 12'h6DE;
   localparam int          SPRITE_SZ   = 16;

   typedef enum logic [1:0] {IDLE, DAMAGE, HEAL} heart_state_t;
endpackage

// File: rtl/heart_sprite_rom.sv
// 32x16 heart sprite ROM, registered output: rows 0-15 full heart, rows 16-31 empty heart.
// Both halves share one silhouette and differ only in fill colour.
module heart_sprite_rom
   import gui_pkg::*;
(
   input  logic        clk,
   input  logic [4:0]  row,
   input  logic [3:0]  col,
   output logic [11:0] rgb
);

   localparam logic [11:0] FULL_C  = 12'hF22;
   localparam logic [11:0] EMPTY_C = 12'h444;

   logic [15:0] mask;
   logic        opaque;

   // Bit 15 of each mask word is column 0.
   always_comb begin
      mask = 16'h0000;
      case (row[3:0])
         4'd1:  mask = 16'h3838;
         4'd2:  mask = 16'h7C7C;
         4'd3:  mask = 16'hFEFE;
         4'd4:  mask = 16'hFFFE;
         4'd5:  mask = 16'hFFFE;
         4'd6:  mask = 16'hFFFE;
         4'd7:  mask = 16'h7FFC;
         4'd8:  mask = 16'h3FF8;
         4'd9:  mask = 16'h1FF0;
         4'd10: mask = 16'h0FE0;
         4'd11: mask = 16'h07C0;
         4'd12: mask = 16'h0380;
         4'd13: mask = 16'h0100;
         default: mask = 16'h0000;
      endcase
   end

   assign opaque = mask[4'd15 - col];

   always_ff @(posedge clk) begin
      rgb <= !opaque ? TRANSPARENT : (row[4] ? EMPTY_C : FULL_C);
   end

endmodule

// File: rtl/gui_heart_bar.sv
// HUD health bar: draws MAX_HEARTS hearts, blinks lost hearts, refills healed ones per frame.
// Pixel latency 1 cycle; state changes only on frame_tick. Optional low-HP pulse: GUI_HEART_LOWHP_EN.
module gui_heart_bar
   import gui_pkg::*;
#(
   parameter int MAX_HEARTS   = 5,
   parameter int X0           = 30,
   parameter int Y0           = 16,
   parameter int SPACING      = 16,
   parameter int BLINK_FRAMES = 32,
   parameter int BLINK_HALF   = 4,
   parameter int HEAL_STEP    = 4,
   localparam int HW          = $clog2(MAX_HEARTS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [9:0]    x,
   input  logic [9:0]    y,
   input  logic          frame_tick,
   input  logic [HW-1:0] num_heart,
   output logic [11:0]   rgb_out,
   output logic          heart_on
);

   localparam int SP_SH = $clog2(SPACING);
   localparam int BH_SH = $clog2(BLINK_HALF);
   localparam int BW    = $clog2(BLINK_FRAMES + 1);
   localparam int HCW   = (HEAL_STEP > 1) ? $clog2(HEAL_STEP) : 1;

   localparam logic [HW-1:0]  MAXH       = HW'(MAX_HEARTS);
   localparam logic [11:0]    X_LO       = 12'(X0);
   localparam logic [11:0]    X_HI       = 12'(X0 + MAX_HEARTS * SPACING);
   localparam logic [11:0]    Y_LO       = 12'(Y0);
   localparam logic [11:0]    Y_HI       = 12'(Y0 + SPRITE_SZ);
   localparam logic [BW-1:0]  BLINK_LOAD = BW'(BLINK_FRAMES);
   localparam logic [HCW-1:0] HEAL_LOAD  = HCW'(HEAL_STEP - 1);

   if (SPACING < SPRITE_SZ || (SPACING & (SPACING - 1)) != 0) begin : g_bad_spacing
      $error("SPACING must be a power of two and at least 16");
   end
   if (BLINK_HALF < 1 || (BLINK_HALF & (BLINK_HALF - 1)) != 0 || BH_SH >= BW) begin : g_bad_blink
      $error("BLINK_HALF must be a power of two below BLINK_FRAMES");
   end
   if (MAX_HEARTS < 1 || MAX_HEARTS > 15) begin : g_bad_hearts
      $error("MAX_HEARTS must be 1..15");
   end

   heart_state_t   state;
   logic [HW-1:0]  shown, lost_lo, lost_hi, tgt;
   logic [BW-1:0]  blink_cnt;
   logic [HCW-1:0] heal_cnt;
`ifdef GUI_HEART_LOWHP_EN
   logic [4:0]     frame_cnt;
`endif

   logic [11:0] xe, ye, dx;
   logic [3:0]  slot, row_off;
   logic        hit, hit_q, slot_full, damage_lit;
   logic [4:0]  rom_row;
   logic [11:0] rom_rgb;

   assign xe      = {2'b00, x};
   assign ye      = {2'b00, y};
   assign dx      = xe - X_LO;
   assign row_off = 4'(ye - Y_LO);
   assign slot    = 4'(dx >> SP_SH);
   assign hit     = (xe >= X_LO) && (xe < X_HI) && (ye >= Y_LO) && (ye < Y_HI) &&
                    ((dx & 12'(SPACING - 1)) < 12'(SPRITE_SZ));

   // Lost hearts stay lit on the "on" half of each blink period.
   assign damage_lit = (state == DAMAGE) && blink_cnt[BH_SH] &&
                       (4'(lost_lo) <= slot) && (slot < 4'(lost_hi));

   always_comb begin
      slot_full = (slot < 4'(shown)) || damage_lit;
`ifdef GUI_HEART_LOWHP_EN
      if (state == IDLE && shown == HW'(1) && slot == 4'd0 && frame_cnt[4:3] == 2'b11)
         slot_full = 1'b0;
`endif
   end

   assign rom_row = {~slot_full, row_off};

   heart_sprite_rom u_rom (
      .clk (clk),
      .row (rom_row),
      .col (dx[3:0]),
      .rgb (rom_rgb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) hit_q <= 1'b0;
      else        hit_q <= hit;
   end

   assign rgb_out  = hit_q ? rom_rgb : 12'h000;
   assign heart_on = hit_q && (rom_rgb != TRANSPARENT);

   assign tgt = (num_heart > MAXH) ? MAXH : num_heart;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         shown     <= MAXH;
         lost_lo   <= MAXH;
         lost_hi   <= MAXH;
         blink_cnt <= '0;
         heal_cnt  <= '0;
      end else if (frame_tick) begin
         if (tgt < shown) begin
            // A further hit mid-blink widens the range downward only.
            lost_lo   <= tgt;
            if (state != DAMAGE) lost_hi <= shown;
            shown     <= tgt;
            blink_cnt <= BLINK_LOAD;
            state     <= DAMAGE;
         end else if (tgt > shown) begin
            if (state == HEAL) begin
               if (heal_cnt == '0) begin
                  shown    <= shown + HW'(1);
                  heal_cnt <= HEAL_LOAD;
               end else begin
                  heal_cnt <= heal_cnt - HCW'(1);
               end
            end else begin
               lost_lo  <= MAXH;
               lost_hi  <= MAXH;
               heal_cnt <= HEAL_LOAD;
               shown    <= shown + HW'(1);
               state    <= HEAL;
            end
         end else begin
            case (state)
               DAMAGE: begin
                  if (blink_cnt <= BW'(1)) begin
                     blink_cnt <= '0;
                     lost_lo   <= MAXH;
                     lost_hi   <= MAXH;
                     state     <= IDLE;
                  end else begin
                     blink_cnt <= blink_cnt - BW'(1);
                  end
               end
               HEAL:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef GUI_HEART_LOWHP_EN
   always_ff @(posedge clk) begin
      if (!rst_n)          frame_cnt <= '0;
      else if (frame_tick) frame_cnt <= frame_cnt + 5'd1;
   end
`endif

endmodule

// File: tb/tb_gui_heart_bar.sv
// Bench for gui_heart_bar: reset/pixel vector table, directed animation sequences, random health changes.
// Expected pixels come from an integer-arithmetic model of the bar and a private copy of the sprite.
module tb_gui_heart_bar;

   localparam int MAXH = 5, X0 = 30, Y0 = 16, SP = 16;
   localparam int BF = 32, BH = 4, HS = 4;
   localparam logic [11:0] C_T = 12'h6DE, C_F = 12'hF22, C_E = 12'h444;
`ifdef GUI_HEART_LOWHP_EN
   localparam bit LOWHP = 1'b1;
`else
   localparam bit LOWHP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, frame_tick;
   logic [9:0]  x, y, x2, y2;
   logic [2:0]  num_heart;
   logic [11:0] rgb, rgb2;
   logic        on, on2;

   always #5 clk = ~clk;

   gui_heart_bar dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_tick(frame_tick),
      .num_heart(num_heart), .rgb_out(rgb), .heart_on(on)
   );

   gui_heart_bar #(.SPACING(32)) dut2 (
      .clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .frame_tick(frame_tick),
      .num_heart(num_heart), .rgb_out(rgb2), .heart_on(on2)
   );

   int errors = 0, checks = 0;

   // Model: 0 idle, 1 blinking after damage, 2 refilling.
   int m_mode, m_shown, m_lo, m_hi, m_blink_left, m_heal_wait, m_frames;

   task automatic model_reset();
      m_mode = 0; m_shown = MAXH; m_lo = MAXH; m_hi = MAXH;
      m_blink_left = 0; m_heal_wait = 0; m_frames = 0;
   endtask

   task automatic model_tick(int nh);
      int t;
      t = (nh > MAXH) ? MAXH : nh;
      m_frames = (m_frames + 1) % 32;
      if (t < m_shown) begin
         if (m_mode != 1) m_hi = m_shown;
         m_lo = t; m_shown = t; m_blink_left = BF; m_mode = 1;
      end else if (t > m_shown) begin
         if (m_mode == 2) begin
            if (m_heal_wait == 0) begin m_shown++; m_heal_wait = HS - 1; end
            else m_heal_wait--;
         end else begin
            m_lo = MAXH; m_hi = MAXH; m_heal_wait = HS - 1; m_shown++; m_mode = 2;
         end
      end else if (m_mode == 1) begin
         m_blink_left--;
         if (m_blink_left == 0) begin m_mode = 0; m_lo = MAXH; m_hi = MAXH; end
      end else begin
         m_mode = 0;
      end
   endtask

   function automatic logic [15:0] mask_row(int r);
      case (r)
         1: return 16'h3838;  2: return 16'h7C7C;  3: return 16'hFEFE;
         4, 5, 6: return 16'hFFFE;
         7: return 16'h7FFC;  8: return 16'h3FF8;  9: return 16'h1FF0;
         10: return 16'h0FE0; 11: return 16'h07C0; 12: return 16'h0380;
         13: return 16'h0100;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic bit model_full(int i);
      bit f;
      f = (i < m_shown) ||
          (m_mode == 1 && ((m_blink_left / BH) % 2 == 1) && i >= m_lo && i < m_hi);
      if (LOWHP && m_mode == 0 && m_shown == 1 && i == 0 && m_frames >= 24) f = 0;
      return f;
   endfunction

   // Returns {heart_on, rgb_out}.
   function automatic logic [12:0] expect_pix(int px, int py);
      int dx, i, col, row;
      logic [15:0] m;
      if (px < X0 || px >= X0 + MAXH * SP || py < Y0 || py >= Y0 + 16) return 13'd0;
      dx = px - X0;
      if (dx % SP >= 16) return 13'd0;
      i = dx / SP; col = dx % 16; row = py - Y0;
      m = mask_row(row);
      if (!m[15 - col]) return {1'b0, C_T};
      return {1'b1, model_full(i) ? C_F : C_E};
   endfunction

   task automatic check_pix(int px, int py, string nm);
      logic [12:0] exp;
      @(negedge clk); x = 10'(px); y = 10'(py);
      @(negedge clk);
      exp = expect_pix(px, py);
      checks++;
      if ({on, rgb} !== exp) begin
         errors++;
         $display("FAIL %s pix(%0d,%0d): got on=%0b rgb=%h, want on=%0b rgb=%h",
                  nm, px, py, on, rgb, exp[12], exp[11:0]);
      end
   endtask

   task automatic check_bar(string nm);
      for (int i = 0; i < MAXH; i++) check_pix(X0 + i * SP + 5, Y0 + 5, nm);
      check_pix(int'($urandom_range(0, 140)), int'($urandom_range(12, 36)), nm);
   endtask

   task automatic check2(int px, int py, logic [11:0] er, logic eo, string nm);
      @(negedge clk); x2 = 10'(px); y2 = 10'(py);
      @(negedge clk);
      checks++;
      if ({on2, rgb2} !== {eo, er}) begin
         errors++;
         $display("FAIL %s pix(%0d,%0d): got on=%0b rgb=%h, want on=%0b rgb=%h",
                  nm, px, py, on2, rgb2, eo, er);
      end
   endtask

   task automatic tick(int nh);
      @(negedge clk); num_heart = 3'(nh); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      model_tick(nh);
   endtask

   task automatic ticks_checked(int n, int nh, string nm);
      for (int k = 0; k < n; k++) begin tick(nh); check_bar(nm); end
   endtask

   // Reset lands while an opaque pixel is being driven: outputs must drop the next cycle.
   task automatic do_reset(string nm);
      @(negedge clk); rst_n = 1'b0; x = 10'd35; y = 10'd21;
      @(negedge clk);
      checks++;
      if ({on, rgb} !== 13'd0) begin
         errors++;
         $display("FAIL %s: got on=%0b rgb=%h, want on=0 rgb=000", nm, on, rgb);
      end
      @(negedge clk); rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct { int px; int py; logic [11:0] rgb; logic on; } vec_t;
   vec_t vt[10];

   initial begin
      vt[0] = '{30, 16, C_T, 1'b0};    vt[1] = '{35, 21, C_F, 1'b1};
      vt[2] = '{110, 16, 12'h000, 1'b0}; vt[3] = '{29, 21, 12'h000, 1'b0};
      vt[4] = '{99, 21, C_F, 1'b1};    vt[5] = '{35, 15, 12'h000, 1'b0};
      vt[6] = '{35, 32, 12'h000, 1'b0}; vt[7] = '{53, 29, C_F, 1'b1};
      vt[8] = '{54, 29, C_T, 1'b0};    vt[9] = '{77, 19, C_T, 1'b0};

      rst_n = 1'b0; frame_tick = 1'b0; num_heart = 3'd5;
      x = '0; y = '0; x2 = '0; y2 = '0;
      model_reset();
      do_reset("reset_out");

      for (int k = 0; k < 10; k++) begin
         @(negedge clk); x = 10'(vt[k].px); y = 10'(vt[k].py);
         @(negedge clk);
         checks++;
         if ({on, rgb} !== {vt[k].on, vt[k].rgb}) begin
            errors++;
            $display("FAIL vec%0d pix(%0d,%0d): got on=%0b rgb=%h, want on=%0b rgb=%h",
                     k, vt[k].px, vt[k].py, on, rgb, vt[k].on, vt[k].rgb);
         end
      end

      check2(X0 + 20, Y0 + 5, 12'h000, 1'b0, "gap32");
      check2(X0 + 32 + 3, Y0 + 5, C_F, 1'b1, "slot1_col3");
      check2(X0 + 32 + 3, Y0, C_T, 1'b0, "slot1_row0");

      // Damage 5 -> 2: full blink then settle empty.
      ticks_checked(34, 2, "damage5to2");

      // Second hit mid-blink widens lost range to [1,5).
      do_reset("reset2");
      ticks_checked(6, 2, "hit_a");
      ticks_checked(35, 1, "hit_b");

      // Heal 1 -> 4 through to idle.
      ticks_checked(12, 4, "heal1to4");

      // Drop mid-heal: back to 1, heal toward 5, then fall to 3 while shown=4.
      ticks_checked(34, 1, "back_to_1");
      ticks_checked(9, 5, "heal_to5");
      ticks_checked(6, 3, "drop_mid_heal");

      // Reset in the middle of a blink.
      ticks_checked(5, 0, "zero_blink");
      do_reset("reset_mid_blink");
      check_bar("after_reset");

      // Health 1 idle: slot 0 pulses only when the low-HP option is built in.
      ticks_checked(34, 1, "to_one");
      ticks_checked(40, 1, "lowhp");
      for (int k = 0; k < 32; k++) if (m_frames < 25) tick(1);
      check_bar("lowhp_mid");
      do_reset("reset_mid_pulse");
      check_bar("after_pulse_reset");

      // Random health changes, including out-of-range targets that clamp.
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 7) == 0) num_heart = 3'($urandom_range(0, 7));
         tick(int'(num_heart));
         check_bar("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
